// File: rtl/matmul_tile_sequencer_pkg.sv
// matmul_tile_sequencer_pkg: shared state encoding and K-step computation for the tile sequencer
package matmul_tile_sequencer_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;
  function automatic int k_steps(input int inner, input int blk);
    return inner / blk;
  endfunction
endpackage

// File: rtl/tile_index_counter.sv
// tile_index_counter: row-major row/col counter with programmable limits (clk, rst, i_clear, i_inc, i_row_lim, i_col_lim -> o_row, o_col, o_last)
module tile_index_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_inc,
  input  logic [W-1:0] i_row_lim,
  input  logic [W-1:0] i_col_lim,
  output logic [W-1:0] o_row,
  output logic [W-1:0] o_col,
  output logic         o_last
);
  logic [W-1:0] r_row, r_col;
  logic         w_col_wrap;
  assign w_col_wrap = r_col == i_col_lim - W'(1);
  assign o_last     = (r_row == i_row_lim - W'(1)) && w_col_wrap;
  assign o_row      = r_row;
  assign o_col      = r_col;
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_inc) begin
      r_col <= w_col_wrap ? '0 : r_col + W'(1);
      r_row <= w_col_wrap ? r_row + W'(1) : r_row;
    end
  end
endmodule

// File: rtl/matmul_tile_sequencer.sv
// matmul_tile_sequencer: walks the output tile grid, drives operand addresses and core control, returns each tile result over valid/ready
module matmul_tile_sequencer
  import matmul_tile_sequencer_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int CHUNK_SIZE      = 4,
  parameter int BLOCK_SIZE      = 2,
  parameter int INNER_DIMENSION = 64,
  parameter int TILE_IDX_W      = 8,
  parameter int ADDR_WIDTH      = 16,
  parameter int DRAIN_MAX       = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [TILE_IDX_W-1:0]       i_num_row_tiles,
  input  logic [TILE_IDX_W-1:0]       i_num_col_tiles,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_error,
  output logic                        o_rd_en,
  output logic [ADDR_WIDTH-1:0]       o_w_addr,
  output logic [ADDR_WIDTH-1:0]       o_n_addr,
  output logic                        o_core_en,
  output logic                        o_core_reset_acc,
  input  logic                        i_accumulator_done,
  input  logic                        i_systolic_finish,
  input  logic [WIDTH*CHUNK_SIZE-1:0] i_core_out,
  output logic [WIDTH*CHUNK_SIZE-1:0] o_out_data,
  output logic [ADDR_WIDTH-1:0]       o_out_addr,
  output logic                        o_out_valid,
  input  logic                        i_out_ready
);
  localparam int K_STEPS = k_steps(INNER_DIMENSION, BLOCK_SIZE);
  localparam int CNT_W   = $clog2((K_STEPS > DRAIN_MAX ? K_STEPS : DRAIN_MAX) + 1);
  if (INNER_DIMENSION % BLOCK_SIZE != 0) begin : g_bad_dims
    $error("INNER_DIMENSION must be a multiple of BLOCK_SIZE");
  end
  state_t                      r_state, w_next;
  logic [CNT_W-1:0]            r_cnt;
  logic [TILE_IDX_W-1:0]       r_nr, r_nc, w_row, w_col;
  logic [WIDTH*CHUNK_SIZE-1:0] r_out_data;
  logic                        r_rd_d, r_error;
  logic                        w_last, w_empty, w_accept, w_timeout, w_capture, w_inc, w_unused;
  assign w_unused  = i_systolic_finish;
  assign w_empty   = r_nr == '0 || r_nc == '0;
  assign w_accept  = r_state == S_IDLE && i_start;
  assign w_timeout = r_state == S_DRAIN && !i_accumulator_done && r_cnt == CNT_W'(DRAIN_MAX - 1);
  assign w_capture = r_state == S_DRAIN && (i_accumulator_done || w_timeout);
  assign w_inc     = r_state == S_NEXT && !w_empty && !w_last;
  tile_index_counter #(.W(TILE_IDX_W)) u_tiles (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_accept),
    .i_inc     (w_inc),
    .i_row_lim (r_nr),
    .i_col_lim (r_nc),
    .o_row     (w_row),
    .o_col     (w_col),
    .o_last    (w_last)
  );
  // An empty grid still spends one NEXT cycle so the job looks like every other one to the host.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = !i_start ? S_IDLE : (i_num_row_tiles == '0 || i_num_col_tiles == '0) ? S_NEXT : S_CLEAR;
      S_CLEAR: w_next = S_FEED;
      S_FEED:  w_next = r_cnt == CNT_W'(K_STEPS - 1) ? S_DRAIN : S_FEED;
      S_DRAIN: w_next = w_capture ? S_WRITE : S_DRAIN;
      S_WRITE: w_next = i_out_ready ? S_NEXT : S_WRITE;
      S_NEXT:  w_next = (w_empty || w_last) ? S_DONE : S_CLEAR;
      default: w_next = S_IDLE;
    endcase
    o_busy           = r_state != S_IDLE;
    o_done           = r_state == S_DONE;
    o_rd_en          = r_state == S_FEED;
    o_core_reset_acc = r_state == S_CLEAR;
    o_core_en        = r_rd_d || r_state == S_DRAIN;
    o_out_valid      = r_state == S_WRITE;
  end
  // r_cnt is k in FEED and the drain-cycle count in DRAIN; it restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_nr       <= '0;
      r_nc       <= '0;
      r_rd_d     <= 1'b0;
      r_error    <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_state <= w_next;
      r_rd_d  <= r_state == S_FEED;
      r_cnt   <= (w_next != r_state || !(r_state == S_FEED || r_state == S_DRAIN)) ? '0 : r_cnt + 1'b1;
      if (w_accept) begin
        r_nr    <= i_num_row_tiles;
        r_nc    <= i_num_col_tiles;
        r_error <= 1'b0;
      end
      if (w_timeout) r_error <= 1'b1;
      if (w_capture) r_out_data <= i_core_out;
    end
  end
  assign o_error    = r_error;
  assign o_out_data = r_out_data;
  assign o_w_addr   = ADDR_WIDTH'(32'(w_row) * K_STEPS + 32'(r_cnt));
  assign o_n_addr   = ADDR_WIDTH'(32'(w_col) * K_STEPS + 32'(r_cnt));
  assign o_out_addr = ADDR_WIDTH'(32'(w_row) * 32'(r_nc) + 32'(w_col));
endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// tb_matmul_tile_sequencer: directed scoreboard bench for matmul_tile_sequencer
module tb_matmul_tile_sequencer;
  typedef struct packed {
    logic [15:0] addr;
    logic [63:0] data;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_num_row_tiles = '0;
  logic [7:0]  i_num_col_tiles = '0;
  logic        i_accumulator_done = 1'b0;
  logic        i_systolic_finish = 1'b0;
  logic [63:0] i_core_out = '0;
  logic        i_out_ready = 1'b1;
  logic        o_busy, o_done, o_error, o_rd_en, o_core_en, o_core_reset_acc, o_out_valid;
  logic [15:0] o_w_addr, o_n_addr, o_out_addr;
  logic [63:0] o_out_data;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  matmul_tile_sequencer dut (
    .clk                (clk),
    .rst                (rst),
    .i_start            (i_start),
    .i_num_row_tiles    (i_num_row_tiles),
    .i_num_col_tiles    (i_num_col_tiles),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_error            (o_error),
    .o_rd_en            (o_rd_en),
    .o_w_addr           (o_w_addr),
    .o_n_addr           (o_n_addr),
    .o_core_en          (o_core_en),
    .o_core_reset_acc   (o_core_reset_acc),
    .i_accumulator_done (i_accumulator_done),
    .i_systolic_finish  (i_systolic_finish),
    .i_core_out         (i_core_out),
    .o_out_data         (o_out_data),
    .o_out_addr         (o_out_addr),
    .o_out_valid        (o_out_valid),
    .i_out_ready        (i_out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  // Runs one job; the core is modelled by asserting accumulator_done on drain cycle d (never when to=1).
  // bp: cycles of out_ready=0 on the first WRITE; rst_k>=0 aborts with rst at that k of the first tile.
  task automatic run_job(input int nr, input int nc, input int d, input int bp, input bit to,
                         input bit feed_ack, input bit poke, input int rst_k);
    int rt = 0, ct = 0, k = 0, j = 0, cyc = 0, busy_n = 0, ra_n = 0, rd_n = 0, tiles = 0, bp_left = bp;
    int exp_done;
    bit prev_rd = 0, got_done = 0, in_write = 0;
    logic [63:0] held_d, val;
    logic [15:0] held_a;
    exp_t e;
    exp_done = (nr * nc == 0) ? 2 : nr * nc * (35 + (to ? 64 : d)) + bp + 1;
    @(negedge clk);
    i_num_row_tiles = 8'(nr);
    i_num_col_tiles = 8'(nc);
    i_start = 1'b1;
    while (!got_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      i_start = poke && cyc == 5;
      if (poke && cyc == 5) begin
        i_num_row_tiles = 8'd7;
        i_num_col_tiles = 8'd7;
      end
      i_accumulator_done = 1'b0;
      if (cyc == 1) begin
        chk("busy_rise", o_busy, 1);
        chk("error_clear_on_start", o_error, 0);
      end
      if (o_busy) busy_n++;
      if (o_core_reset_acc) ra_n++;
      if (o_rd_en) begin
        rd_n++;
        if (k == 0) chk("reset_acc_before_feed", ra_n, 1);
        if (tiles == 0 && k == 0) chk("first_rd_en_cycle", cyc, 2);
        chk("w_addr", o_w_addr, rt * 32 + k);
        chk("n_addr", o_n_addr, ct * 32 + k);
        chk("core_en_lag", o_core_en, prev_rd);
        if (feed_ack && k == 5) i_accumulator_done = 1'b1;
        if (rst_k >= 0 && k == rst_k) begin
          rst = 1'b1;
          @(negedge clk);
          chk("rst_busy", o_busy, 0);
          chk("rst_rd_en", o_rd_en, 0);
          chk("rst_core_en", o_core_en, 0);
          rst = 1'b0;
          return;
        end
        k++;
      end else if (o_core_en) begin
        j++;
        if (j == 1) begin
          val = {$urandom, $urandom};
          i_core_out = val;
          sb.push_back('{16'(rt * nc + ct), val});
          chk("feed_len", k, 32);
        end
        i_accumulator_done = !to && j == d;
      end
      if (in_write && !o_out_valid) chk("valid_held", o_out_valid, 1);
      if (o_out_valid) begin
        if (!in_write) begin
          in_write = 1;
          chk("drain_len", j, to ? 64 : d);
          chk("error_flag", o_error, to);
          held_d = o_out_data;
          held_a = o_out_addr;
        end else begin
          chk("data_stable", o_out_data, held_d);
          chk("addr_stable", o_out_addr, held_a);
        end
        chk("rd_en_in_write", o_rd_en, 0);
        chk("core_en_in_write", o_core_en, 0);
        if (bp_left > 0) begin
          bp_left--;
          i_out_ready = 1'b0;
        end else begin
          i_out_ready = 1'b1;
          if (sb.size() == 0) chk("scoreboard_empty", 1, 0);
          else begin
            e = sb.pop_front();
            chk("out_addr", o_out_addr, e.addr);
            chk("out_data", o_out_data, e.data);
          end
          tiles++;
          k = 0;
          j = 0;
          ra_n = 0;
          in_write = 0;
          ct++;
          if (ct == nc) begin
            ct = 0;
            rt++;
          end
        end
      end
      if (o_done) begin
        got_done = 1;
        chk("done_cycle", cyc, exp_done);
      end
      prev_rd = o_rd_en;
    end
    i_start = 1'b0;
    if (!got_done) chk("done_timeout", 0, 1);
    chk("tiles_written", tiles, nr * nc);
    chk("scoreboard_drained", sb.size(), 0);
    chk("rd_en_count", rd_n, nr * nc * 32);
    chk("busy_cycles", busy_n, exp_done);
    @(negedge clk);
    chk("done_one_cycle", o_done, 0);
    chk("idle_after_done", o_busy, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy0", o_busy, 0);
    chk("rst_done0", o_done, 0);
    chk("rst_error0", o_error, 0);
    chk("rst_rd_en0", o_rd_en, 0);
    chk("rst_core_en0", o_core_en, 0);
    chk("rst_reset_acc0", o_core_reset_acc, 0);
    chk("rst_out_valid0", o_out_valid, 0);
    chk("rst_w_addr0", o_w_addr, 0);
    chk("rst_n_addr0", o_n_addr, 0);
    chk("rst_out_addr0", o_out_addr, 0);
    chk("rst_out_data0", o_out_data, 0);
    rst = 1'b0;
    run_job(1, 1, 5, 0, 0, 0, 0, -1);
    run_job(2, 3, 3, 0, 0, 1, 0, -1);
    run_job(1, 2, 4, 10, 0, 0, 0, -1);
    run_job(3, 0, 0, 0, 0, 0, 0, -1);
    run_job(1, 1, 0, 0, 1, 0, 0, -1);
    chk("error_sticky", o_error, 1);
    run_job(1, 1, 2, 0, 0, 0, 0, -1);
    run_job(1, 1, 5, 0, 0, 0, 0, 10);
    chk("abort_scoreboard", sb.size(), 0);
    run_job(2, 2, 2, 0, 0, 0, 1, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
